mem_copy_dma: RTL

Memory-side initiator that drives the instruction ROM read port and the data RAM write port. On a start pulse it copies a block of words from ROM to RAM: it issues ROM reads, absorbs the ROM's one-cycle registered read latency, and writes each word to RAM at one word per cycle. It also reports a 32-bit additive checksum of the copied data. It sits between the core's control logic and the ROM/RAM pair, and preloads weights and constants into RAM before a PIM kernel runs.

---
 rtl/mem_copy_dma_if.sv | 27 ++
 rtl/mem_copy_dma.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_copy_dma_if.sv
// Bundle of control, status and ROM/RAM port signals for mem_copy_dma.
// master is the copy engine's view; slave is the core/memory side.
interface mem_copy_dma_if;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] sum;
    logic [31:0] rom_A;
    logic [31:0] rom_Q;
    logic [31:0] ram_A;
    logic [31:0] ram_D;
    logic        ram_WE;

    modport master (
        input  start, src, dst, len, rom_Q,
        output busy, done, err, sum, rom_A, ram_A, ram_D, ram_WE
    );

    modport slave (
        output start, src, dst, len, rom_Q,
        input  busy, done, err, sum, rom_A, ram_A, ram_D, ram_WE
    );
endinterface

// File: rtl/mem_copy_dma.sv
// ROM-to-RAM block copier: one word per cycle behind the ROM's registered read,
// with a running 32-bit additive checksum of the words written.
module mem_copy_dma #(
    parameter int unsigned ROM_LEN = 128,
    parameter int unsigned RAM_LEN = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    mem_copy_dma_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e      state_q;
    logic [31:0] dst_q;
    logic [31:0] len_q;
    logic [31:0] rd_idx_q;
    logic [31:0] wr_idx_q;
    logic [31:0] rom_A_q;
    logic [31:0] ram_A_q;
    logic        ram_WE_q;
    logic [31:0] sum_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [32:0] src_end_d;
    logic [32:0] dst_end_d;
    logic        range_ok_d;
    logic        len_zero_d;
    logic        last_rd_d;
    logic        last_wr_d;

    // 33-bit sums so a huge src/dst/len cannot wrap back into range
    assign src_end_d  = {1'b0, bus.src} + {1'b0, bus.len};
    assign dst_end_d  = {1'b0, bus.dst} + {1'b0, bus.len};
    assign range_ok_d = (src_end_d <= 33'(ROM_LEN)) && (dst_end_d <= 33'(RAM_LEN));
    assign len_zero_d = (bus.len == '0);
    assign last_rd_d  = (rd_idx_q == len_q - 32'd1);
    assign last_wr_d  = (wr_idx_q == len_q - 32'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            len_q    <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            rom_A_q  <= '0;
            ram_A_q  <= '0;
            ram_WE_q <= 1'b0;
            sum_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (!range_ok_d) begin
                            err_q <= 1'b1;
                        end else if (len_zero_d) begin
                            sum_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dst_q    <= bus.dst;
                            len_q    <= bus.len;
                            rd_idx_q <= '0;
                            wr_idx_q <= '0;
                            rom_A_q  <= bus.src;
                            ram_WE_q <= 1'b0;
                            sum_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end

                RUN: begin
                    // Read stage: advance until the last address, then hold it
                    if (!last_rd_d) begin
                        rd_idx_q <= rd_idx_q + 32'd1;
                        rom_A_q  <= rom_A_q + 32'd1;
                    end
                    // Write stage trails the read stage by the ROM latency
                    if (ram_WE_q) begin
                        sum_q <= sum_q + bus.rom_Q;
                        if (last_wr_d) begin
                            ram_WE_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            wr_idx_q <= wr_idx_q + 32'd1;
                            ram_A_q  <= ram_A_q + 32'd1;
                        end
                    end else begin
                        ram_WE_q <= 1'b1;
                        ram_A_q  <= dst_q;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q  <= IDLE;
                    ram_WE_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.sum    = sum_q;
    assign bus.rom_A  = rom_A_q;
    assign bus.ram_A  = ram_A_q;
    assign bus.ram_WE = ram_WE_q;
    assign bus.ram_D  = bus.rom_Q;

endmodule
